// File: rtl/booth_seq_arbiter_pkg.sv
// booth_seq_arbiter_pkg: FSM states, Booth step ops and recoding helper
package booth_seq_arbiter_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    typedef enum logic [1:0] {NOP = 2'd0, ADD = 2'd1, SUB = 2'd2} op_t;
    function automatic op_t decode(input logic [1:0] qq);
        return qq == 2'b10 ? SUB : qq == 2'b01 ? ADD : NOP;
    endfunction
endpackage

// File: rtl/booth_seq_arbiter_if.sv
// booth_seq_arbiter_if: two requester channels, one result channel and busy
interface booth_seq_arbiter_if #(parameter int W = 8);
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic signed [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic res_valid, res_ready, res_id, busy;
    logic signed [2*W-1:0] res_prod;
    modport slave(
        input req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
        output req0_ready, req1_ready, res_valid, res_prod, res_id, busy
    );
    modport master(
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
        input req0_ready, req1_ready, res_valid, res_prod, res_id, busy
    );
endinterface

// File: rtl/booth_seq_arbiter_step.sv
// booth_seq_arbiter_step: one radix-2 Booth add/sub followed by arithmetic right shift
module booth_seq_arbiter_step import booth_seq_arbiter_pkg::*; #(
    parameter int W = 8
) (
    input  logic [W:0]   a,
    input  logic [W-1:0] q,
    input  logic         q_m1,
    input  logic [W:0]   m,
    output logic [W:0]   a_n,
    output logic [W-1:0] q_n,
    output logic         q_m1_n
);
    op_t op;
    logic [W:0] sum;
    always_comb begin
        op = decode({q[0], q_m1});
        sum = op == SUB ? a - m : op == ADD ? a + m : a;
        {a_n, q_n, q_m1_n} = {sum[W], sum, q};
    end
endmodule

// File: rtl/booth_seq_arbiter.sv
// booth_seq_arbiter: round-robin shared sequential Booth multiplier, one step per clock
module booth_seq_arbiter import booth_seq_arbiter_pkg::*; #(
    parameter int W = 8
) (
    input logic clk,
    input logic rst,
    booth_seq_arbiter_if.slave bus
);
    localparam int CW = $clog2(W + 1);
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic last_grant, id, sel, accept, last_step, q_m1, q_m1_n, id_r;
    logic [W:0] a, m, a_n;
    logic [W-1:0] q, q_n;
    logic [2*W-1:0] prod_r;

    assign sel = bus.req0_valid && bus.req1_valid ? !last_grant : bus.req1_valid;
    assign bus.req0_ready = state == IDLE && !rst && bus.req0_valid && !sel;
    assign bus.req1_ready = state == IDLE && !rst && bus.req1_valid && sel;
    assign accept = bus.req0_ready | bus.req1_ready;
    assign last_step = state == RUN && cnt == CW'(W - 1);
    assign bus.res_valid = state == DONE;
    assign bus.busy = state != IDLE;
    assign bus.res_prod = prod_r;
    assign bus.res_id = id_r;

    booth_seq_arbiter_step #(.W(W)) u_step (
        .a(a), .q(q), .q_m1(q_m1), .m(m),
        .a_n(a_n), .q_n(q_n), .q_m1_n(q_m1_n)
    );

    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (accept ? RUN : IDLE)
                : state == RUN  ? (last_step ? DONE : RUN)
                : (bus.res_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            last_grant <= 1'b1;
            id <= 1'b0;
            a <= '0;
            q <= '0;
            q_m1 <= 1'b0;
            m <= '0;
            prod_r <= '0;
            id_r <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                a <= '0;
                q <= sel ? bus.req1_a : bus.req0_a;
                q_m1 <= 1'b0;
                m <= sel ? {bus.req1_b[W-1], bus.req1_b} : {bus.req0_b[W-1], bus.req0_b};
                cnt <= '0;
                id <= sel;
                last_grant <= sel;
            end else if (state == RUN) begin
                a <= a_n;
                q <= q_n;
                q_m1 <= q_m1_n;
                cnt <= cnt + 1'b1;
                if (last_step) begin
                    prod_r <= {a_n[W-1:0], q_n};
                    id_r <= id;
                end
            end
        end
    end
endmodule

// File: tb/tb_booth_seq_arbiter.sv
// tb_booth_seq_arbiter: scoreboard bench, expected products from plain signed multiplication
module tb_booth_seq_arbiter;
    localparam int W = 8;
    typedef struct {
        logic signed [2*W-1:0] prod;
        logic id;
        int acc;
    } exp_t;

    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    booth_seq_arbiter_if #(.W(W)) bus();
    booth_seq_arbiter #(.W(W)) dut(.clk(clk), .rst(rst), .bus(bus));

    exp_t sb[$];
    exp_t e;
    int gq[$];
    int tests = 0, fails = 0, cyc = 0;
    int acc_cnt[2] = '{0, 0};
    logic prev_rv = 0, prev_hold = 0, prev_id = 0, done = 0;
    logic signed [2*W-1:0] prev_prod = '0;

    task automatic chk(input string name, input logic ok, input longint act, input longint exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: handshakes are decided at the negedge and commit on the next posedge
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            prev_rv = 0;
            prev_hold = 0;
            chk("ready_in_rst", !bus.req0_ready && !bus.req1_ready, {bus.req0_ready, bus.req1_ready}, 0);
        end else begin
            chk("one_ready", !(bus.req0_ready && bus.req1_ready), {bus.req0_ready, bus.req1_ready}, 0);
            if (bus.busy)
                chk("ready_busy", !bus.req0_ready && !bus.req1_ready, {bus.req0_ready, bus.req1_ready}, 0);
            if (prev_hold) begin
                chk("hold_valid", bus.res_valid, bus.res_valid, 1);
                chk("hold_prod", bus.res_prod == prev_prod, bus.res_prod, prev_prod);
                chk("hold_id", bus.res_id == prev_id, bus.res_id, prev_id);
            end
            if (bus.res_valid && !prev_rv && sb.size() > 0)
                chk("latency", cyc - sb[0].acc == W, cyc - sb[0].acc, W);
            if (bus.res_valid && bus.res_ready) begin
                if (sb.size() == 0) chk("unexpected_result", 0, bus.res_prod, 0);
                else begin
                    e = sb.pop_front();
                    chk("prod", bus.res_prod == e.prod, bus.res_prod, e.prod);
                    chk("id", bus.res_id == e.id, bus.res_id, e.id);
                end
            end
            if (bus.req0_valid && bus.req0_ready) begin
                sb.push_back('{prod: (2*W)'(longint'(bus.req0_a) * longint'(bus.req0_b)), id: 1'b0, acc: cyc + 1});
                gq.push_back(0);
                acc_cnt[0]++;
            end
            if (bus.req1_valid && bus.req1_ready) begin
                sb.push_back('{prod: (2*W)'(longint'(bus.req1_a) * longint'(bus.req1_b)), id: 1'b1, acc: cyc + 1});
                gq.push_back(1);
                acc_cnt[1]++;
            end
            prev_rv = bus.res_valid;
            prev_hold = bus.res_valid && !bus.res_ready;
            prev_prod = bus.res_prod;
            prev_id = bus.res_id;
        end
    end

    // entered and left just after a posedge; valid is dropped once accepted
    task automatic send(input int r, input int a, input int b);
        int start, n;
        start = acc_cnt[r];
        n = 0;
        if (r == 0) begin
            bus.req0_valid = 1; bus.req0_a = a[W-1:0]; bus.req0_b = b[W-1:0];
        end else begin
            bus.req1_valid = 1; bus.req1_a = a[W-1:0]; bus.req1_b = b[W-1:0];
        end
        while (acc_cnt[r] == start && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (acc_cnt[r] == start) chk("accept_timeout", 0, r, -1);
        if (r == 0) bus.req0_valid = 0; else bus.req1_valid = 0;
    endtask

    task automatic expect_res(input string name, input logic [2*W-1:0] p, input logic i);
        int n;
        n = 0;
        while (!bus.res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_valid"}, bus.res_valid, bus.res_valid, 1);
        chk(name, bus.res_prod == p, bus.res_prod, p);
        chk({name, "_id"}, bus.res_id == i, bus.res_id, i);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() > 0 || bus.busy) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", sb.size() == 0 && !bus.busy, sb.size(), 0);
    endtask

    task automatic pulse_rst();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.req0_a = 0; bus.req0_b = 0; bus.req1_a = 0; bus.req1_b = 0;
        bus.res_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", !bus.res_valid, bus.res_valid, 0);
        chk("rst_busy", !bus.busy, bus.busy, 0);
        chk("rst_prod", bus.res_prod == 0, bus.res_prod, 0);
        chk("rst_id", !bus.res_id, bus.res_id, 0);
        @(posedge clk); #1;
        rst = 0;

        send(0, -16, -16);    expect_res("m16xm16", 16'h0100, 0);
        send(0, -128, -128);  expect_res("min_sq", 16'h4000, 0);
        send(1, -128, 127);   expect_res("min_max", 16'hC080, 1);
        send(0, 7, 0);        expect_res("times_zero", 16'h0000, 0);
        drain();

        pulse_rst();
        gq.delete();
        fork
            for (int i = 0; i < 3; i++) send(0, $urandom, $urandom);
            for (int i = 0; i < 3; i++) send(1, $urandom, $urandom);
        join
        drain();
        chk("grant_count", gq.size() == 6, gq.size(), 6);
        for (int i = 0; i < 6 && i < gq.size(); i++) chk("grant_order", gq[i] == i % 2, gq[i], i % 2);

        bus.res_ready = 0;
        send(0, 13, -11);
        while (!bus.res_valid) @(negedge clk);
        @(posedge clk); #1;
        fork send(1, 3, 4); join_none
        repeat (5) begin
            @(negedge clk);
            chk("stall_prod", bus.res_prod == -143, bus.res_prod, -143);
            chk("stall_r1", !bus.req1_ready, bus.req1_ready, 0);
        end
        @(posedge clk); #1;
        bus.res_ready = 1;
        repeat (20) @(posedge clk);
        #1;
        drain();

        send(0, 5, 3);
        repeat (4) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", !bus.busy, bus.busy, 0);
        chk("abort_valid", !bus.res_valid, bus.res_valid, 0);
        @(posedge clk); #1;
        rst = 0;
        send(0, 1, 1); expect_res("after_abort", 16'h0001, 0);
        drain();

        fork
            begin
                fork
                    for (int i = 0; i < 500; i++) begin
                        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                        send(0, $urandom, $urandom);
                    end
                    for (int i = 0; i < 500; i++) begin
                        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                        send(1, $urandom, $urandom);
                    end
                join
                done = 1;
            end
            while (!done) begin
                @(posedge clk); #1;
                bus.res_ready = $urandom_range(0, 3) != 0;
            end
        join
        bus.res_ready = 1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
